// File: rtl/merge2_rr.sv
// merge2_rr: two-input, one-output packet merge with round-robin arbitration.
//
// Recombines two packet streams onto a single link. Each input is buffered
// in a small FIFO; the output is a registered valid/ready stage carrying a
// source tag (out_src) that mirrors the select channel of the 2-way decoder.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in0_valid  input 0 packet present
//   in0_data   input 0 packet (W bits, [8:5] = destination, passed through)
//   in0_ready  input 0 FIFO can accept
//   in1_valid  input 1 packet present
//   in1_data   input 1 packet
//   in1_ready  input 1 FIFO can accept
//   out_valid  output packet present
//   out_data   output packet
//   out_src    0 = packet came from in0, 1 = packet came from in1
//   out_ready  downstream accepts
module merge2_rr #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem0 [DEPTH];
  logic [W-1:0]  mem1 [DEPTH];
  logic [PW-1:0] wp0, rp0, wp1, rp1;
  logic [CW-1:0] cnt0, cnt1;
  logic          prio;

  logic push0, push1, pop0, pop1;
  logic ne0, ne1;
  logic load_en, grant, winner;

  // Ready depends only on occupancy; reset forces it low while asserted.
  assign in0_ready = !reset && (cnt0 < FULL);
  assign in1_ready = !reset && (cnt1 < FULL);

  assign push0 = in0_valid && in0_ready;
  assign push1 = in1_valid && in1_ready;
  assign ne0   = (cnt0 != '0);
  assign ne1   = (cnt1 != '0);

  assign load_en = !out_valid || out_ready;
  assign grant   = load_en && (ne0 || ne1);

  // The favoured input wins if it has data; otherwise the other one does.
  always_comb begin
    winner = 1'b0;
    if (prio) winner = ne1 ? 1'b1 : 1'b0;
    else      winner = ne0 ? 1'b0 : 1'b1;
  end

  assign pop0 = grant && !winner;
  assign pop1 = grant &&  winner;

  // Storage is not reset: occupancy counters alone define validity.
  always_ff @(posedge clk) begin
    if (push0) mem0[wp0] <= in0_data;
    if (push1) mem1[wp1] <= in1_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp0  <= '0;
      rp0  <= '0;
      cnt0 <= '0;
    end else begin
      if (push0) wp0 <= wp0 + 1'b1;
      if (pop0)  rp0 <= rp0 + 1'b1;
      case ({push0, pop0})
        2'b10:   cnt0 <= cnt0 + 1'b1;
        2'b01:   cnt0 <= cnt0 - 1'b1;
        default: cnt0 <= cnt0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else begin
      if (push1) wp1 <= wp1 + 1'b1;
      if (pop1)  rp1 <= rp1 + 1'b1;
      case ({push1, pop1})
        2'b10:   cnt1 <= cnt1 + 1'b1;
        2'b01:   cnt1 <= cnt1 - 1'b1;
        default: cnt1 <= cnt1;
      endcase
    end
  end

  // Output register. With both FIFOs empty on a load, only valid drops;
  // data and tag keep their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      prio      <= 1'b0;
    end else if (load_en) begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= winner ? mem1[rp1] : mem0[rp0];
        out_src   <= winner;
        prio      <= ~winner;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/merge2_rr.md
Name: merge2_rr

Overview:
- Two-input, one-output packet merge with round-robin arbitration.
- It is the converging counterpart of the 2-way address decoder in the NoC router: it recombines two packet streams, one of which may be a decoder output, onto a single link toward the next router stage.
- Each input has a small FIFO.
- The output is registered and carries a source tag identifying the winning input. This tag mirrors the decoder's select channel.
- It is a clocked valid/ready implementation intended for the synthesized router fabric.

Parameters:
W, 9, packet width in bits; bits [8:5] are the destination address and are passed through untouched.
DEPTH, 2, entries per input FIFO; power of two, >= 2.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in0_valid  in  1  input 0 packet present.
in0_data  in  W  input 0 packet.
in0_ready  out  1  input 0 FIFO can accept.
in1_valid  in  1  input 1 packet present.
in1_data  in  W  input 1 packet.
in1_ready  out  1  input 1 FIFO can accept.
out_valid  out  1  output packet present.
out_data  out  W  output packet.
out_src  out  1  0 = packet came from in0, 1 = packet came from in1.
out_ready  in  1  downstream accepts.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Both FIFOs are emptied and the occupancy counters set to 0.
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer prio=0 (in0 is favoured first).
  - in0_ready and in1_ready read 1 once reset is deasserted; they are 0 while reset is high.
  - Reset asserted mid-operation drops all buffered and output packets without emitting them.
- Input handshake:
  - A transfer occurs on a rising edge where inX_valid && inX_ready.
  - inX_ready = (occupancy of FIFO X < DEPTH). It is derived from registered state only and has no combinational path from out_ready or from inX_valid.
- FIFOs:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is a counter of log2(DEPTH)+1 bits.
  - A simultaneous push and pop in the same cycle leaves the count unchanged.
  - A push is impossible when the FIFO is full.
  - A pop on an empty FIFO never occurs.
- Output register:
  - The output register loads when it is empty or is being drained this cycle (load_en = !out_valid || out_ready).
  - On load_en, if at least one FIFO is non-empty:
    - Winner = prio if FIFO[prio] is non-empty, otherwise the other input.
    - The winner's head is popped into out_data, and out_src=winner, out_valid=1.
    - prio is updated to ~winner.
  - On load_en with both FIFOs empty: out_valid=0, and out_data and out_src hold their previous values.
  - When only one input is non-empty it wins regardless of prio; prio still becomes ~winner.
  - While out_valid && !out_ready: out_data and out_src are held stable, no pop occurs, and prio is unchanged.
- Latency and throughput:
  - A packet accepted at edge k is visible on the output no earlier than after edge k+1. There is no bypass path.
  - Sustained throughput is 1 packet per cycle with out_ready held high.
  - With both inputs saturated, outputs strictly alternate between in0 and in1.
- Ordering: packets from the same input leave in arrival order.
- Data integrity: out_data equals the accepted input word bit-for-bit.

Test Plan:
1. Reset, then in0 sends 9'h1A5 alone with out_ready=1 -> after 1 cycle out_valid=1, out_data=9'h1A5, out_src=0; in1_ready stays 1 throughout.
2. Both inputs valid every cycle (in0: 9'h100,9'h101,...; in1: 9'h080,9'h081,...), out_ready=1 -> output order is 100(src0), 080(src1), 101(src0), 081(src1), ..., one packet per cycle.
3. out_ready=0 while in1 pushes 4 packets with DEPTH=2 -> 3 accepted (1 in the output register, 2 in the FIFO), then in1_ready=0; out_data stays the first packet. Releasing out_ready drains all 3 in order.
4. Only in1 active for 3 packets, then both active -> the first contended grant goes to in0, because prio=~1=0.
5. Reset asserted while out_valid=1 and both FIFOs hold data -> out_valid=0 immediately; after release no stale packet appears; prio=0.
6. Random valid/ready traffic for 10k cycles -> per-input order preserved, no loss or duplication, out_src correct, and no input starves for more than 2 consecutive grants while it is non-empty.
